// File: rtl/vga_timing_controller_if.sv
//==============================================================================
// Module   : vga_timing_controller_if
// Purpose  : VRAM address and VGA sync/active bundle from the raster generator.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface vga_timing_controller_if;
    logic [13:0] pixel_address;
    logic        VGA_HSYNC;
    logic        VGA_VSYNC;
    logic        video_active;

    modport master (
        output pixel_address,
        output VGA_HSYNC,
        output VGA_VSYNC,
        output video_active
    );

    modport slave (
        input pixel_address,
        input VGA_HSYNC,
        input VGA_VSYNC,
        input video_active
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_controller.sv
//==============================================================================
// Module   : vga_timing_controller
// Purpose  : 640x480@60 VGA raster timing with 5x upscaled 128x96 VRAM addressing.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_timing_controller #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 5,
    parameter int IMG_W    = 128,
    parameter int IMG_H    = 96
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    vga_timing_controller_if.master   vga
);

    localparam int c_H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int c_H_SYNC_END = c_H_SYNC_BEG + H_SYNC;
    localparam int c_V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int c_V_SYNC_END = c_V_SYNC_BEG + V_SYNC;
    localparam int c_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_X_W        = $clog2(IMG_W);
    localparam int c_Y_W        = $clog2(IMG_H);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [9:0]         r_h_cnt;
    logic [9:0]         r_v_cnt;
    logic [2:0]         r_x_sub;
    logic [2:0]         r_y_sub;
    logic [c_X_W-1:0]   r_x_img;
    logic [c_Y_W-1:0]   r_y_img;

    logic [13:0]        r_addr;
    logic               r_hs1;
    logic               r_vs1;
    logic               r_act1;
    logic               r_hs2;
    logic               r_vs2;
    logic               r_act2;

    logic w_pix_en;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_active;
    logic w_hs;
    logic w_vs;
    logic w_x_sub_last;
    logic w_y_sub_last;

    assign w_pix_en     = (r_div_cnt == c_DIV_W'(CLK_DIV - 1));
    assign w_h_wrap     = (r_h_cnt == 10'(c_H_TOTAL - 1));
    assign w_v_wrap     = (r_v_cnt == 10'(c_V_TOTAL - 1));
    assign w_active     = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
    assign w_hs         = !((r_h_cnt >= 10'(c_H_SYNC_BEG)) && (r_h_cnt < 10'(c_H_SYNC_END)));
    assign w_vs         = !((r_v_cnt >= 10'(c_V_SYNC_BEG)) && (r_v_cnt < 10'(c_V_SYNC_END)));
    assign w_x_sub_last = (r_x_sub == 3'(SCALE - 1));
    assign w_y_sub_last = (r_y_sub == 3'(SCALE - 1));

    // Image coordinates only advance while the next screen pixel/line is still
    // visible, so they saturate at the last image pixel instead of overrunning.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_x_sub   <= '0;
            r_x_img   <= '0;
            r_y_sub   <= '0;
            r_y_img   <= '0;
        end else begin
            r_div_cnt <= w_pix_en ? '0 : r_div_cnt + c_DIV_W'(1);
            if (w_pix_en) begin
                if (w_h_wrap) begin
                    r_h_cnt <= '0;
                    r_x_sub <= '0;
                    r_x_img <= '0;
                    if (w_v_wrap) begin
                        r_v_cnt <= '0;
                        r_y_sub <= '0;
                        r_y_img <= '0;
                    end else begin
                        r_v_cnt <= r_v_cnt + 10'd1;
                        if (r_v_cnt < 10'(V_ACTIVE - 1)) begin
                            if (w_y_sub_last) begin
                                r_y_sub <= '0;
                                r_y_img <= r_y_img + c_Y_W'(1);
                            end else begin
                                r_y_sub <= r_y_sub + 3'd1;
                            end
                        end
                    end
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                    if (w_active && (r_h_cnt < 10'(H_ACTIVE - 1))) begin
                        if (w_x_sub_last) begin
                            r_x_sub <= '0;
                            r_x_img <= r_x_img + c_X_W'(1);
                        end else begin
                            r_x_sub <= r_x_sub + 3'd1;
                        end
                    end
                end
            end
        end
    end

    // Stage 2 trails stage 1 by the VRAM read latency so sync, active and
    // colour all change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_act1 <= 1'b0;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
            r_act2 <= 1'b0;
        end else begin
            r_addr <= w_active ? 14'({r_y_img, r_x_img}) : '0;
            r_hs1  <= w_hs;
            r_vs1  <= w_vs;
            r_act1 <= w_active;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_act2 <= r_act1;
        end
    end

    assign vga.pixel_address = r_addr;
    assign vga.VGA_HSYNC     = r_hs2;
    assign vga.VGA_VSYNC     = r_vs2;
    assign vga.video_active  = r_act2;

endmodule

`default_nettype wire

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock.
- Drives the 14-bit pixel_address into the VRAM stage directly downstream. VRAM holds a 128x96 one-bit-per-colour image, upscaled 5x in each axis.
- Produces VGA_HSYNC, VGA_VSYNC and video_active. These are delayed to line up with the 1-cycle BRAM read latency of VRAM's colour outputs.

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz -> 25 MHz pixel rate).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SCALE, 5: screen pixels per image pixel, both axes.
- IMG_W, 128: image width (power of two, 7 address bits).
- IMG_H, 96: image height.

Ports:
- clk  input  1  system clock, 100 MHz, rising edge.
- reset  input  1  synchronous, active-high reset.
- pixel_address  output  14  VRAM read address = {y_img[6:0], x_img[6:0]}.
- VGA_HSYNC  output  1  horizontal sync, active low.
- VGA_VSYNC  output  1  vertical sync, active low.
- video_active  output  1  high when the VRAM colour outputs belong to a visible pixel; downstream blanks colour when low.

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high, and sampled on every rising clk edge.
- Reset values, valid on the edge reset is sampled high:
  - div_cnt = 0, h_cnt = 0, v_cnt = 0.
  - x_sub = 0, x_img = 0, y_sub = 0, y_img = 0.
  - pixel_address = 0.
  - VGA_HSYNC = 1, VGA_VSYNC = 1, video_active = 0.
  - All pipeline registers take the same inactive values.
- Reset mid-frame aborts immediately. No partial-line completion.
- Pixel enable: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt == CLK_DIV-1). All raster counters advance only on pix_en.
- Horizontal counter: h_cnt counts 0..799 and wraps to 0. On wrap, v_cnt advances 0..524 and wraps to 0.
- Frame timing: line = 3200 clocks, frame = 1,680,000 clocks.
- Active region: h_cnt < 640 and v_cnt < 480.
- Horizontal scaling:
  - Within the active region, x_sub counts 0..SCALE-1. When x_sub wraps, x_img increments.
  - At h_cnt wrap, x_sub and x_img clear to 0.
- Vertical scaling:
  - At each h_cnt wrap, y_sub increments. When y_sub wraps, y_img increments.
  - At v_cnt wrap, y_sub and y_img clear to 0.
- Value ranges: x_img never exceeds 127; y_img never exceeds 95.
- Stage 1 (registered), computed from the current counters:
  - pixel_address = {y_img, x_img} when active, else 0.
  - hs1 = 0 when h_cnt is in 656..751, else 1.
  - vs1 = 0 when v_cnt is in 490..491, else 1.
  - act1 = active.
- Stage 2 (registered, 1 clock after stage 1): VGA_HSYNC, VGA_VSYNC and video_active are hs1, vs1 and act1 delayed by one clock. This matches the VRAM BRAM read latency, so colour, sync and active flag change on the same edge.
- pixel_address is held constant for the whole CLK_DIV-clock pixel slot.
- Counter wrap conditions (h, v, sub, img) are mutually consistent when they coincide. At h=799 and v=524 on pix_en, all counters return to 0 together.
- Width rules:
  - h_cnt and v_cnt are 10 bits.
  - x_sub and y_sub are 3 bits.
  - x_img and y_img are 7 bits.
  - No multiplier; the address is formed by concatenation.

Test Plan:
- Reset: hold reset 3 clocks -> pixel_address=0, VGA_HSYNC=1, VGA_VSYNC=1, video_active=0. Release reset -> video_active rises exactly 2 clocks after the first counter state (0,0); VGA_HSYNC and VGA_VSYNC stay 1.
- Horizontal scaling, line 0: pixel_address=0 for 20 clocks, then 1 for 20 clocks, ..., 127 at h=635..639. Then pixel_address=0 and video_active low for 160 pixels (640 clocks).
- Horizontal sync: VGA_HSYNC falls 656*4=2624 clocks after the stage-2 line start, stays low 384 clocks, and repeats every 3200 clocks.
- Vertical scaling and sync:
  - Lines 0-4 start at address 0; line 5 starts at 128.
  - Line 479 ends with address 12287 (y_img=95, x_img=127).
  - VGA_VSYNC is low for lines 490-491 (6400 clocks) and repeats every 1,680,000 clocks.
- Frame wrap: after v=524 and h=799, the next frame's first address is 0, with x_sub and y_sub restarted. The first active pixel occurs exactly 1,680,000 clocks after the previous frame's first active pixel.
- Reset mid-frame: assert reset at v=300, h=400 for 1 clock -> next edge gives all reset values; the raster restarts from (0,0) with identical timing to power-up.
